// File: rtl/keccak_absorb_arbiter.sv
// Round-robin arbiter in front of the hash_core ififo write port: locks one requester
// for a whole message, then appends SHA-3/SHAKE padding up to the rate boundary.
module keccak_absorb_arbiter #(
   parameter int NREQ = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   din,
   input  logic [NREQ-1:0]      last,
   input  logic [2*NREQ-1:0]    mode,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      grant,
   output logic                 busy,
   input  logic                 ififo_afull,
   output logic                 ififo_wen,
   output logic [31:0]          ififo_din,
   output logic [1:0]           ififo_mode,
   output logic                 ififo_last,
   output logic                 ififo_msg_end,
   output logic [2:0]           dbg_state
);

   localparam logic [31:0] PAD_END = 32'h8000_0000;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DATA = 3'd1,
      S_PAD  = 3'd2,
      S_ZERO = 3'd3,
      S_END  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [1:0]      owner_q, owner_d;
   logic [1:0]      mode_q, mode_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [5:0]      rate_q, rate_d;
   logic [5:0]      word_ctr_q, word_ctr_d;
   logic [7:0]      dom_q, dom_d;
   logic            wen_q, wen_d;
   logic [31:0]     din_q, din_d;
   logic            last_q, last_d;
   logic            msg_end_q, msg_end_d;

   logic [31:0]     sel_din;
   logic            sel_last;
   logic            pick_found;
   logic [1:0]      pick_idx;
   logic [1:0]      pick_mode;
   logic            at_last;
   logic            at_pre_last;
   logic [5:0]      ctr_inc;

   function automatic logic [5:0] rate_of(input logic [1:0] m);
      case (m)
         2'd0:    rate_of = 6'd18;
         2'd2:    rate_of = 6'd42;
         default: rate_of = 6'd34;
      endcase
   endfunction

   function automatic logic [7:0] dom_of(input logic [1:0] m);
      dom_of = m[1] ? 8'h1F : 8'h06;
   endfunction

   // Round-robin pick: requesters at or above ptr win first, then wrap to the low indices.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 2'd0;
      pick_mode  = 2'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_found && req[i] && (2'(i) >= ptr_q)) begin
            pick_found = 1'b1;
            pick_idx   = 2'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_found && req[i]) begin
            pick_found = 1'b1;
            pick_idx   = 2'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == 2'(i)) begin
            pick_mode = mode[2*i +: 2];
         end
      end
   end

   always_comb begin
      sel_din  = 32'h0;
      sel_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_q == 2'(i)) begin
            sel_din  = din[32*i +: 32];
            sel_last = last[i];
         end
      end
   end

   assign at_last     = (word_ctr_q == rate_q - 6'd1);
   assign at_pre_last = (word_ctr_q == rate_q - 6'd2);
   assign ctr_inc     = at_last ? 6'd0 : word_ctr_q + 6'd1;

   // Handshake: a word moves when ack[i] is high at a clock edge; ack = grant & req & ~afull
   // only in DATA, so the requester must hold req/din/last stable until it sees ack.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      mode_d     = mode_q;
      grant_d    = grant_q;
      rate_d     = rate_q;
      dom_d      = dom_q;
      word_ctr_d = word_ctr_q;
      wen_d      = 1'b0;
      din_d      = din_q;
      last_d     = 1'b0;
      msg_end_d  = 1'b0;
      ack        = '0;

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               owner_d    = pick_idx;
               grant_d    = '0;
               for (int i = 0; i < NREQ; i++) begin
                  if (pick_idx == 2'(i)) grant_d[i] = 1'b1;
               end
               mode_d     = pick_mode;
               rate_d     = rate_of(pick_mode);
               dom_d      = dom_of(pick_mode);
               word_ctr_d = 6'd0;
               state_d    = S_DATA;
            end
         end

         S_DATA: begin
            ack = grant_q & req & {NREQ{~ififo_afull}};
            if (|ack) begin
               wen_d      = 1'b1;
               din_d      = sel_din;
               last_d     = at_last;
               word_ctr_d = ctr_inc;
               if (sel_last) state_d = S_PAD;
            end
         end

         S_PAD: begin
            if (!ififo_afull) begin
               wen_d      = 1'b1;
               din_d      = {24'h0, dom_q} | (at_last ? PAD_END : 32'h0);
               last_d     = at_last;
               word_ctr_d = ctr_inc;
               if (at_last) begin
                  msg_end_d = 1'b1;
                  state_d   = S_DONE;
               end else if (at_pre_last) begin
                  state_d = S_END;
               end else begin
                  state_d = S_ZERO;
               end
            end
         end

         S_ZERO: begin
            if (!ififo_afull) begin
               wen_d      = 1'b1;
               din_d      = 32'h0;
               word_ctr_d = ctr_inc;
               if (at_pre_last) state_d = S_END;
            end
         end

         S_END: begin
            if (!ififo_afull) begin
               wen_d      = 1'b1;
               din_d      = PAD_END;
               last_d     = 1'b1;
               msg_end_d  = 1'b1;
               word_ctr_d = ctr_inc;
               state_d    = S_DONE;
            end
         end

         S_DONE: begin
            grant_d = '0;
            ptr_d   = (owner_q == 2'(NREQ - 1)) ? 2'd0 : owner_q + 2'd1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= 2'd0;
         owner_q    <= 2'd0;
         mode_q     <= 2'd0;
         grant_q    <= '0;
         rate_q     <= 6'd0;
         dom_q      <= 8'd0;
         word_ctr_q <= 6'd0;
         wen_q      <= 1'b0;
         din_q      <= 32'h0;
         last_q     <= 1'b0;
         msg_end_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         mode_q     <= mode_d;
         grant_q    <= grant_d;
         rate_q     <= rate_d;
         dom_q      <= dom_d;
         word_ctr_q <= word_ctr_d;
         wen_q      <= wen_d;
         din_q      <= din_d;
         last_q     <= last_d;
         msg_end_q  <= msg_end_d;
      end
   end

   assign grant         = grant_q;
   assign busy          = (state_q != S_IDLE);
   assign ififo_wen     = wen_q;
   assign ififo_din     = din_q;
   assign ififo_mode    = mode_q;
   assign ififo_last    = last_q;
   assign ififo_msg_end = msg_end_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_keccak_absorb_arbiter.sv
// Scoreboard bench for keccak_absorb_arbiter: each message's padded write stream is
// modelled up front and compared word by word against the ififo write port.
module tb_keccak_absorb_arbiter;

   localparam int NREQ = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [32*NREQ-1:0]  din;
   logic [NREQ-1:0]     last;
   logic [2*NREQ-1:0]   mode;
   logic [NREQ-1:0]     ack;
   logic [NREQ-1:0]     grant;
   logic                busy;
   logic                ififo_afull;
   logic                ififo_wen;
   logic [31:0]         ififo_din;
   logic [1:0]          ififo_mode;
   logic                ififo_last;
   logic                ififo_msg_end;
   logic [2:0]          dbg_state;

   int          checks  = 0;
   int          errors  = 0;
   int          nwrites = 0;
   bit          sb_en   = 1'b1;
   // entry = {grant, mode, last, msg_end, data}
   logic [38:0] exp_q[$];
   logic [31:0] msg_w[$];
   int          ord_q[$];

   always #5 clk = ~clk;

   keccak_absorb_arbiter #(.NREQ(NREQ)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .din           (din),
      .last          (last),
      .mode          (mode),
      .ack           (ack),
      .grant         (grant),
      .busy          (busy),
      .ififo_afull   (ififo_afull),
      .ififo_wen     (ififo_wen),
      .ififo_din     (ififo_din),
      .ififo_mode    (ififo_mode),
      .ififo_last    (ififo_last),
      .ififo_msg_end (ififo_msg_end),
      .dbg_state     (dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Write-port monitor / scoreboard
   initial begin
      logic [38:0] e;
      forever begin
         @(negedge clk);
         if (!rst && ififo_wen) begin
            nwrites++;
            if (sb_en) begin
               if (exp_q.size() == 0) begin
                  check("wr_unexpected", {ififo_last, ififo_msg_end, ififo_din}, 64'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("wr", {grant, ififo_mode, ififo_last, ififo_msg_end, ififo_din}, e);
               end
            end
         end
      end
   end

   task automatic push_exp(input int r, input int m, input logic [31:0] w,
                           input logic l, input logic e);
      logic [2:0] g;
      g = 3'b001 << r;
      exp_q.push_back({g, 2'(m), l, e, w});
   endtask

   // Padded stream: data, then dom / zeros / 0x80000000 up to the rate boundary.
   task automatic model_msg(input int r, input int m);
      int          rate;
      int          n;
      int          k;
      logic [31:0] dom;
      rate = (m == 0) ? 18 : (m == 2) ? 42 : 34;
      dom  = (m >= 2) ? 32'h1F : 32'h06;
      n    = msg_w.size();
      for (int i = 0; i < n; i++) push_exp(r, m, msg_w[i], (i % rate) == rate - 1, 1'b0);
      k = n % rate;
      if (k == rate - 1) begin
         push_exp(r, m, dom | 32'h8000_0000, 1'b1, 1'b1);
      end else begin
         push_exp(r, m, dom, 1'b0, 1'b0);
         for (int j = 0; j < rate - 2 - k; j++) push_exp(r, m, 32'h0, 1'b0, 1'b0);
         push_exp(r, m, 32'h8000_0000, 1'b1, 1'b1);
      end
   endtask

   task automatic drive_msg(input int r, input int m);
      int   i;
      int   n;
      int   budget;
      logic acc;
      n = msg_w.size();
      mode[2*r +: 2] = 2'(m);
      din[32*r +: 32] = msg_w[0];
      last[r] = (n == 1);
      req[r]  = 1'b1;
      i = 0;
      budget = 0;
      while (i < n && budget < 4000) begin
         @(negedge clk);
         acc = ack[r];
         @(posedge clk);
         #1;
         budget++;
         if (acc) begin
            i++;
            if (i < n) begin
               din[32*r +: 32] = msg_w[i];
               last[r] = (i == n - 1);
            end else begin
               req[r]  = 1'b0;
               last[r] = 1'b0;
            end
         end
      end
      if (i < n) begin
         check("drive_timeout", i, n);
         req[r]  = 1'b0;
         last[r] = 1'b0;
      end
   endtask

   task automatic wait_drain(input string tag);
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || busy) && budget < 4000) begin
         @(negedge clk);
         budget++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic send_msg(input int r, input int m, input int n);
      msg_w.delete();
      for (int i = 0; i < n; i++) msg_w.push_back($urandom);
      nwrites = 0;
      model_msg(r, m);
      drive_msg(r, m);
      wait_drain("drain");
   endtask

   // One-word message for requester r, queued in expected grant order.
   task automatic prep_one(input int r, input int m);
      logic [31:0] w;
      w = $urandom;
      din[32*r +: 32] = w;
      mode[2*r +: 2]  = 2'(m);
      msg_w.delete();
      msg_w.push_back(w);
      model_msg(r, m);
      ord_q.push_back(r);
   endtask

   task automatic drive_multi(input logic [2:0] mask);
      logic [2:0] a;
      int         budget;
      budget = 0;
      req  = mask;
      last = mask;
      while (req != 3'b000 && budget < 1000) begin
         @(negedge clk);
         a = ack;
         if (a != 3'b000) check("rr_ack", a, 3'b001 << ord_q.pop_front());
         @(posedge clk);
         #1;
         req  = req & ~a;
         last = last & ~a;
         budget++;
      end
      check("rr_done", req, 3'b000);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_wen"},   ififo_wen, 0);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_din"},   ififo_din, 0);
      check({tag, "_flags"}, {ififo_last, ififo_msg_end, ififo_mode}, 0);
      check({tag, "_ack"},   ack, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   initial begin
      int   budget;
      int   cnt;
      int   held;
      logic acc;
      rst = 1'b1;
      req = '0;
      last = '0;
      din = '0;
      mode = '0;
      ififo_afull = 1'b0;
      repeat (2) @(negedge clk);
      check_quiet("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Short message, then block-boundary cases
      send_msg(0, 1, 2);
      check("t1_cnt", nwrites, 34);
      send_msg(0, 1, 33);
      check("t2a_cnt", nwrites, 34);
      send_msg(0, 3, 33);
      check("t2b_cnt", nwrites, 34);
      send_msg(0, 1, 34);
      check("t3_cnt", nwrites, 68);
      send_msg(0, 0, $urandom_range(1, 40));

      // Round robin from a fresh ptr
      pulse_reset();
      prep_one(0, 0);
      prep_one(1, 2);
      prep_one(2, 3);
      drive_multi(3'b111);
      wait_drain("rr1_drain");
      prep_one(0, 1);
      prep_one(2, 0);
      drive_multi(3'b101);
      wait_drain("rr2_drain");

      // Backpressure in the middle of the zero run
      msg_w.delete();
      repeat (2) msg_w.push_back($urandom);
      nwrites = 0;
      model_msg(0, 2);
      drive_msg(0, 2);
      budget = 0;
      while (nwrites < 10 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("t5_reach", nwrites >= 10, 1);
      @(posedge clk);
      #1;
      ififo_afull = 1'b1;
      held = -1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         check("stall_wen", ififo_wen, 0);
         if (held >= 0) check("stall_hold", nwrites, held);
         held = nwrites;
      end
      ififo_afull = 1'b0;
      wait_drain("t5_drain");
      check("t5_cnt", nwrites, 42);

      // Asynchronous reset in the middle of DATA
      msg_w.delete();
      for (int i = 0; i < 20; i++) msg_w.push_back($urandom);
      sb_en = 1'b0;
      mode[1:0] = 2'd1;
      din[31:0] = msg_w[0];
      last[0] = 1'b0;
      req[0] = 1'b1;
      cnt = 0;
      budget = 0;
      while (cnt < 10 && budget < 500) begin
         @(negedge clk);
         acc = ack[0];
         @(posedge clk);
         #1;
         budget++;
         if (acc) begin
            cnt++;
            din[31:0] = msg_w[cnt];
         end
      end
      check("t6_acks", cnt, 10);
      #2;
      rst = 1'b1;
      #1;
      check_quiet("midrst");
      req = '0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      sb_en = 1'b1;
      send_msg(1, 0, 1);
      check("t6_cnt", nwrites, 18);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
